// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the write-back arbiter.
// This covers register-file geometry, requester indices and register-index helpers.
package wb_arbiter_pkg;

  localparam int WB_WIDTH = 32;
  localparam int WB_NUM   = 64;
  localparam int WB_NREQ  = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_FPU = 1;
  localparam int REQ_LSU = 2;

  // General r0 is hardwired zero, so it is never written and never marked pending.
  localparam logic [5:0] GEN_R0_IDX = 6'd0;

  function automatic logic [5:0] reg_idx(input logic gfflag, input logic [4:0] num);
    return {gfflag, num};
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the issue stage, the write-back producers and the arbiter.
// It also carries the registered write port and the scoreboard.
interface wb_arbiter_if #(
  parameter int WIDTH = wb_arbiter_pkg::WB_WIDTH,
  parameter int NUM   = wb_arbiter_pkg::WB_NUM,
  parameter int NREQ  = wb_arbiter_pkg::WB_NREQ
);

  logic                   issue_valid;
  logic                   issue_gfflag;
  logic [4:0]             issue_num;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_gfflag;
  logic [5*NREQ-1:0]      req_num;
  logic [WIDTH*NREQ-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;

  logic                   w_gfflag;
  logic [4:0]             w_num;
  logic [WIDTH-1:0]       w_data;
  logic                   w_enable;

  logic [NUM-1:0]         busy;

  modport slave (
    input  issue_valid, issue_gfflag, issue_num,
    input  req_valid, req_gfflag, req_num, req_data,
    output req_ready,
    output w_gfflag, w_num, w_data, w_enable,
    output busy
  );

  modport master (
    output issue_valid, issue_gfflag, issue_num,
    output req_valid, req_gfflag, req_num, req_data,
    input  req_ready,
    input  w_gfflag, w_num, w_data, w_enable,
    input  busy
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant.
// It picks the first requester with req high, searching upward from ptr with wrap-around.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  always_comb begin
    logic w_found;
    // NOTE: every output of a combinational block gets a default first, else a latch is inferred.
    o_grant = '0;
    w_found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && (i == (int'(i_ptr) + off) % NREQ) && i_req[i]) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port among the ALU, FPU and LSU.
// It also tracks a pending-write bit per register for hazard detection.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int WIDTH = WB_WIDTH,
  parameter  int NUM   = WB_NUM,
  parameter  int NREQ  = WB_NREQ,
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  bus
);

  logic [PW-1:0]    r_ptr;
  logic             r_w_gfflag;
  logic [4:0]       r_w_num;
  logic [WIDTH-1:0] r_w_data;
  logic             r_w_enable;
  logic [NUM-1:0]   r_busy;

  logic [NREQ-1:0]  w_grant;
  logic             w_accept;
  logic             w_win_gfflag;
  logic [4:0]       w_win_num;
  logic [WIDTH-1:0] w_win_data;
  logic [PW-1:0]    w_ptr_next;
  logic [5:0]       w_win_idx;
  logic [5:0]       w_issue_idx;
  logic [NUM-1:0]   w_busy_next;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // A grant is only ever given to a valid requester, so any grant is an accept.
  assign bus.req_ready = w_grant;
  assign w_accept      = |w_grant;

  always_comb begin
    w_win_gfflag = 1'b0;
    w_win_num    = '0;
    w_win_data   = '0;
    w_ptr_next   = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_win_gfflag = bus.req_gfflag[i];
        w_win_num    = bus.req_num[5*i +: 5];
        w_win_data   = bus.req_data[WIDTH*i +: WIDTH];
        w_ptr_next   = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign w_win_idx   = reg_idx(w_win_gfflag, w_win_num);
  assign w_issue_idx = reg_idx(bus.issue_gfflag, bus.issue_num);

  // Set is applied after clear: a newly issued producer owns the register.
  always_comb begin
    w_busy_next = r_busy;
    if (w_accept)
      w_busy_next[w_win_idx] = 1'b0;
    if (bus.issue_valid && (w_issue_idx != GEN_R0_IDX))
      w_busy_next[w_issue_idx] = 1'b1;
  end

  // NOTE: the busy vector is plain flops, not RAM, so it can and must clear on async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr      <= '0;
      r_w_gfflag <= 1'b0;
      r_w_num    <= '0;
      r_w_data   <= '0;
      r_w_enable <= 1'b0;
      r_busy     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      r_ptr      <= w_ptr_next;
      r_busy     <= w_busy_next;
      r_w_enable <= w_accept && (w_win_idx != GEN_R0_IDX);
      if (w_accept) begin
        r_w_gfflag <= w_win_gfflag;
        r_w_num    <= w_win_num;
        r_w_data   <= w_win_data;
      end
    end
  end

  assign bus.w_gfflag = r_w_gfflag;
  assign bus.w_num    = r_w_num;
  assign bus.w_data   = r_w_data;
  assign bus.w_enable = r_w_enable;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// It covers arbitration order, the write stage, the scoreboard, r0 handling and async reset.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int NUM   = 64;
  localparam int NREQ  = 3;
  localparam logic [63:0] BIT35 = 64'h0000_0008_0000_0000;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  wb_arbiter_if #(.WIDTH(WIDTH), .NUM(NUM), .NREQ(NREQ)) bus ();

  wb_arbiter #(.WIDTH(WIDTH), .NUM(NUM), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_gfflag = 1'b0;
    bus.issue_num    = '0;
    bus.req_valid    = '0;
    bus.req_gfflag   = '0;
    bus.req_num      = '0;
    bus.req_data     = '0;
  endtask

  task automatic set_req(input int k, input logic gf, input logic [4:0] num, input logic [31:0] data);
    bus.req_valid[k]         = 1'b1;
    bus.req_gfflag[k]        = gf;
    bus.req_num[5*k +: 5]    = num;
    bus.req_data[32*k +: 32] = data;
  endtask

  task automatic issue(input logic gf, input logic [4:0] num);
    bus.issue_valid  = 1'b1;
    bus.issue_gfflag = gf;
    bus.issue_num    = num;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    #2;
    rstn = 1'b1;
  endtask

  logic [2:0] fair_exp [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

  initial begin
    rstn = 1'b0;
    clear_inputs();
    #3;
    check("rst_w_enable", 64'(bus.w_enable), 64'd0);
    check("rst_w_gfflag", 64'(bus.w_gfflag), 64'd0);
    check("rst_w_num", 64'(bus.w_num), 64'd0);
    check("rst_w_data", 64'(bus.w_data), 64'd0);
    check("rst_busy", bus.busy, 64'd0);
    bus.req_valid = 3'b110;
    #1;
    check("rst_ready_ptr0", 64'(bus.req_ready), 64'b010);
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;

    // Single ALU write to general r5.
    set_req(REQ_ALU, 1'b0, 5'd5, 32'h1234);
    #1;
    check("single_ready", 64'(bus.req_ready), 64'b001);
    tick();
    check("single_w_enable", 64'(bus.w_enable), 64'd1);
    check("single_w_gfflag", 64'(bus.w_gfflag), 64'd0);
    check("single_w_num", 64'(bus.w_num), 64'd5);
    check("single_w_data", 64'(bus.w_data), 64'h1234);
    clear_inputs();
    tick();
    check("idle_w_enable", 64'(bus.w_enable), 64'd0);
    check("idle_w_data_hold", 64'(bus.w_data), 64'h1234);

    // All three contend from reset; each drops after its accept.
    apply_reset();
    set_req(REQ_ALU, 1'b0, 5'd1, 32'hA1);
    set_req(REQ_FPU, 1'b1, 5'd2, 32'hB2);
    set_req(REQ_LSU, 1'b0, 5'd3, 32'hC3);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("cont_ready_%0d", k), 64'(bus.req_ready), 64'(3'b001 << k));
      tick();
      check($sformatf("cont_w_enable_%0d", k), 64'(bus.w_enable), 64'd1);
      check($sformatf("cont_w_num_%0d", k), 64'(bus.w_num), 64'(k + 1));
      bus.req_valid[k] = 1'b0;
    end

    // ALU and LSU continuously valid, FPU idle.
    set_req(REQ_ALU, 1'b0, 5'd6, 32'h11);
    set_req(REQ_LSU, 1'b0, 5'd7, 32'h22);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fair_ready_%0d", k), 64'(bus.req_ready), 64'(fair_exp[k]));
      tick();
    end
    clear_inputs();

    // Scoreboard on float f3 (index 35).
    issue(1'b1, 5'd3);
    tick();
    clear_inputs();
    check("sb_set_f3", bus.busy, BIT35);
    set_req(REQ_FPU, 1'b1, 5'd3, 32'hF3);
    #1;
    check("sb_fpu_ready", 64'(bus.req_ready), 64'b010);
    tick();
    clear_inputs();
    check("sb_clear_f3", bus.busy, 64'd0);
    check("sb_w_enable", 64'(bus.w_enable), 64'd1);
    check("sb_w_gfflag", 64'(bus.w_gfflag), 64'd1);
    issue(1'b1, 5'd3);
    tick();
    check("sb_reissue_f3", bus.busy, BIT35);
    set_req(REQ_FPU, 1'b1, 5'd3, 32'hF4);
    #1;
    check("sb_same_ready", 64'(bus.req_ready), 64'b010);
    tick();
    clear_inputs();
    check("sb_set_wins", bus.busy, BIT35);

    // General r0: never pending, accepted but never written.
    issue(1'b0, 5'd0);
    tick();
    clear_inputs();
    check("r0_busy", bus.busy, BIT35);
    set_req(REQ_ALU, 1'b0, 5'd0, 32'hFFFF);
    #1;
    check("r0_ready", 64'(bus.req_ready), 64'b001);
    tick();
    clear_inputs();
    check("r0_w_enable", 64'(bus.w_enable), 64'd0);
    check("r0_w_data", 64'(bus.w_data), 64'hFFFF);

    // Async reset mid-cycle with pending bits and an active write.
    issue(1'b0, 5'd1);
    set_req(REQ_FPU, 1'b0, 5'd2, 32'h55);
    #1;
    check("ar_ready", 64'(bus.req_ready), 64'b010);
    tick();
    clear_inputs();
    check("ar_pre_w_enable", 64'(bus.w_enable), 64'd1);
    check("ar_pre_busy", bus.busy, BIT35 | 64'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_busy", bus.busy, 64'd0);
    check("ar_w_enable", 64'(bus.w_enable), 64'd0);
    check("ar_w_data", 64'(bus.w_data), 64'd0);
    #1;
    rstn = 1'b1;
    set_req(REQ_ALU, 1'b0, 5'd8, 32'h1);
    set_req(REQ_FPU, 1'b0, 5'd9, 32'h2);
    set_req(REQ_LSU, 1'b0, 5'd10, 32'h3);
    #1;
    check("ar_ptr0_ready", 64'(bus.req_ready), 64'b001);
    tick();
    check("ar_post_w_num", 64'(bus.w_num), 64'd8);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
